// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    // Controller states; the encoding is fixed so that waveforms stay readable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZDIV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Default operand width and the matching iteration-counter width.
    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    // Counter width needed to hold the value w (the iteration count).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// Combinational N-bit subtractor D = X + ~Y + 1 built on carry-lookahead
// generate/propagate terms; borrow_o is high when X < Y.
module cla_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;

    assign g_s = x_i & ~y_i;
    assign p_s = x_i ^ ~y_i;

    // Lookahead carries: each carry is a sum of products of generate terms
    // and the propagate chain below them, with carry-in fixed at 1.
    always_comb begin
        logic acc_s;
        logic prop_s;
        acc_s  = 1'b0;
        prop_s = 1'b1;
        c_s    = '0;
        c_s[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc_s  = 1'b0;
            prop_s = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc_s  = acc_s | (prop_s & g_s[j]);
                prop_s = prop_s & p_s[j];
            end
            c_s[i+1] = acc_s | prop_s;
        end
    end

    assign diff_o   = p_s ^ c_s[N-1:0];
    assign borrow_o = ~c_s[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock using a
// CLA subtractor, with a single-cycle shortcut for a zero divisor.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] dvd_q,    dvd_d;     // dividend, becomes quotient
    logic [WIDTH-1:0] dvs_q,    dvs_d;     // divisor
    logic [WIDTH:0]   p_q,      p_d;       // partial remainder
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] quo_q,    quo_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic             dbz_q,    dbz_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [2*WIDTH:0] pd_shift_s;
    logic [WIDTH:0]   p_shift_s;
    logic [WIDTH-1:0] dvd_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH:0]   p_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    // {P, dividend} shifted left by one; the dividend MSB moves into P.
    assign pd_shift_s  = {p_q, dvd_q} << 1;
    assign p_shift_s   = pd_shift_s[2*WIDTH:WIDTH];
    assign dvd_shift_s = pd_shift_s[WIDTH-1:0];

    cla_sub #(.N(WIDTH + 1)) u_sub (
        .x_i      (p_shift_s),
        .y_i      ({1'b0, dvs_q}),
        .diff_o   (trial_s),
        .borrow_o (borrow_s)
    );

    // Restore on borrow; otherwise keep the difference and record a 1 bit.
    assign p_next_s   = borrow_s ? p_shift_s : trial_s;
    assign dvd_next_s = dvd_shift_s | {{(WIDTH-1){1'b0}}, ~borrow_s};

    // Next-state, datapath and output-register logic for the controller.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = A;
                    dvs_d   = B;
                    p_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = (B != '0) ? RUN : ZDIV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d = dvd_next_s;
                p_d   = p_next_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = dvd_next_s;
                    rem_d   = p_next_s[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            ZDIV: begin
                quo_d   = '1;
                rem_d   = dvd_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Q           = quo_q;
    assign R           = rem_q;
    assign div_by_zero = dbz_q;

endmodule
